// File: rtl/led_uart_tx_pkg.sv
// Shared definitions for the LED-to-UART logger: FSM encodings and default bit timing.
package led_uart_tx_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // 50 MHz system clock, 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop strobes; a push into a full FIFO is accepted only
// when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [CntW-1:0]       count
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  do_push, do_pop;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers are exactly log2(depth) wide so they wrap without extra logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/led_uart_tx.sv
// Queues LED-write bytes and serialises each as an 8N1 UART frame, LSB first.
module led_uart_tx
  import led_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oTx,
  output logic                  oBusy,
  output logic                  oFull,
  output logic                  oOverflow
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(DATA_WIDTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [BaudW-1:0]      baud_q, baud_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q, ovf_d;

  logic                  pop, full, empty, baud_last;
  logic [DATA_WIDTH-1:0] rdata;
  logic [CntW-1:0]       count;

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (Clock),
    .rst_n(Reset),
    .push (iValid),
    .wdata(iData),
    .pop  (pop),
    .rdata(rdata),
    .full (full),
    .empty(empty),
    .count(count)
  );

  assign baud_last = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BaudW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      UART_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = rdata;
          state_d = UART_START;
        end
      end
      UART_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = UART_DATA;
        end
      end
      UART_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitLast) state_d = UART_STOP;
          else                  bit_d   = bit_q + BitW'(1);
        end
      end
      UART_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames abut.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = rdata;
            state_d = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end
      end
      default: state_d = UART_IDLE;
    endcase

    // Line level is derived from the next state so oTx comes straight from a flop.
    tx_d = 1'b1;
    if (state_d == UART_START)     tx_d = 1'b0;
    else if (state_d == UART_DATA) tx_d = shift_d[0];

    ovf_d = ovf_q | (iValid & full & ~pop);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oTx       = tx_q;
  assign oFull     = full;
  assign oOverflow = ovf_q;
  assign oBusy     = (state_q != UART_IDLE) | (count != '0);

endmodule

// File: tb/tb_led_uart_tx.sv
// Self-checking bench for led_uart_tx with 4 clocks per bit and a 4-entry queue.
module tb_led_uart_tx;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iValid = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oTx, oBusy, oFull, oOverflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 is the first bit on the line
  } vec_t;

  vec_t vecs[5];

  // Receiver-side monitor results
  logic [7:0] rx_q[$];
  int         st_q[$];
  int         cyc = 0;
  bit         mon_active = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;

  led_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4),
    .DATA_WIDTH  (8)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iValid   (iValid),
    .iData    (iData),
    .oTx      (oTx),
    .oBusy    (oBusy),
    .oFull    (oFull),
    .oOverflow(oOverflow)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decodes frames from oTx independently of the DUT's internals.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      cyc++;
      if (!Reset) begin
        mon_active = 0;
      end else if (!mon_active) begin
        if (oTx === 1'b0) begin
          mon_active = 1;
          mon_cnt    = 0;
          st_q.push_back(cyc);
        end
      end else begin
        mon_cnt++;
        if (mon_cnt >= 5 && mon_cnt <= 33 && (mon_cnt % 4) == 1)
          mon_byte[(mon_cnt - 4) / 4] = oTx;
        if (mon_cnt == 37) begin
          check("mon_stop_bit", {31'd0, oTx}, 32'd1);
          rx_q.push_back(mon_byte);
        end
        if (mon_cnt == 39) mon_active = 0;
      end
    end
  end

  task automatic push(input logic [7:0] d);
    @(negedge Clock);
    iValid = 1'b1;
    iData  = d;
    @(posedge Clock);
    #1;
    iValid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    @(negedge Clock);
    Reset = 1'b1;
    rx_q.delete();
    st_q.delete();
  endtask

  task automatic expect_frame(input logic [9:0] f, input string name);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge Clock);
        #1;
        check($sformatf("%s_bit%0d_cyc%0d", name, k, c), {31'd0, oTx}, {31'd0, f[k]});
      end
    end
  endtask

  task automatic check_abut(input string name);
    for (int i = 1; i < st_q.size(); i++)
      check($sformatf("%s_start_gap%0d", name, i), st_q[i] - st_q[i-1], 32'd40);
  endtask

  initial begin
    int bad;
    logic [7:0] exp_rx[$];

    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, frame: 10'b1001111000};
    vecs[4] = '{data: 8'h81, frame: 10'b1100000010};

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("rst_tx", {31'd0, oTx}, 32'd1);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_full", {31'd0, oFull}, 32'd0);
    check("rst_ovf", {31'd0, oOverflow}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    // Long idle stretch
    bad = 0;
    repeat (1000) begin
      @(posedge Clock);
      #1;
      if (oTx !== 1'b1 || oBusy !== 1'b0) bad++;
    end
    check("idle1000_bad_cycles", bad, 32'd0);

    // Single frames from the vector table
    foreach (vecs[i]) begin
      rx_q.delete();
      st_q.delete();
      push(vecs[i].data);
      expect_frame(vecs[i].frame, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_busy_last_stop", i), {31'd0, oBusy}, 32'd1);
      @(posedge Clock);
      #1;
      check($sformatf("vec%0d_idle_tx", i), {31'd0, oTx}, 32'd1);
      check($sformatf("vec%0d_idle_busy", i), {31'd0, oBusy}, 32'd0);
      check($sformatf("vec%0d_rx_count", i), rx_q.size(), 32'd1);
      if (rx_q.size() > 0) check($sformatf("vec%0d_rx", i), {24'd0, rx_q[0]}, {24'd0, vecs[i].data});
    end

    // Six back-to-back pushes: the sixth is dropped
    do_reset();
    @(negedge Clock);
    iValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      iData = 8'(i + 1);
      @(posedge Clock);
      #1;
      if (i == 3) check("burst_full_after4", {31'd0, oFull}, 32'd0);
      if (i == 4) check("burst_full_after5", {31'd0, oFull}, 32'd1);
      if (i == 4) check("burst_ovf_after5", {31'd0, oOverflow}, 32'd0);
      if (i == 5) check("burst_ovf_after6", {31'd0, oOverflow}, 32'd1);
    end
    iValid = 1'b0;
    repeat (200) @(posedge Clock);
    #1;
    check("burst_rx_count", rx_q.size(), 32'd5);
    for (int i = 0; i < rx_q.size() && i < 5; i++)
      check($sformatf("burst_rx%0d", i), {24'd0, rx_q[i]}, i + 1);
    check_abut("burst");
    check("burst_ovf_sticky", {31'd0, oOverflow}, 32'd1);
    check("burst_done_busy", {31'd0, oBusy}, 32'd0);
    check("burst_done_full", {31'd0, oFull}, 32'd0);

    // Push while full on the stop-bit pop edge is accepted
    do_reset();
    @(negedge Clock);
    iValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iData = 8'h10 + 8'(i);
      @(posedge Clock);
      #1;
    end
    iValid = 1'b0;
    repeat (36) @(posedge Clock);
    #1;
    check("popedge_full_before", {31'd0, oFull}, 32'd1);
    iValid = 1'b1;
    iData  = 8'h15;
    @(posedge Clock);
    #1;
    iValid = 1'b0;
    check("popedge_ovf", {31'd0, oOverflow}, 32'd0);
    check("popedge_full_after", {31'd0, oFull}, 32'd1);
    check("popedge_tx_start", {31'd0, oTx}, 32'd0);
    repeat (220) @(posedge Clock);
    #1;
    check("popedge_rx_count", rx_q.size(), 32'd6);
    for (int i = 0; i < rx_q.size() && i < 6; i++)
      check($sformatf("popedge_rx%0d", i), {24'd0, rx_q[i]}, 32'h10 + i);
    check_abut("popedge");
    check("popedge_ovf_end", {31'd0, oOverflow}, 32'd0);

    // Reset mid-frame abandons the frame and the queue
    do_reset();
    @(negedge Clock);
    iValid = 1'b1;
    iData  = 8'hFF;
    @(posedge Clock);
    #1;
    iData = 8'h11;
    @(posedge Clock);
    #1;
    iData = 8'h22;
    @(posedge Clock);
    #1;
    iValid = 1'b0;
    repeat (12) @(posedge Clock);
    #1;
    check("midrst_tx_before", {31'd0, oTx}, 32'd1);
    check("midrst_busy_before", {31'd0, oBusy}, 32'd1);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    check("midrst_tx", {31'd0, oTx}, 32'd1);
    check("midrst_busy", {31'd0, oBusy}, 32'd0);
    check("midrst_full", {31'd0, oFull}, 32'd0);
    check("midrst_ovf", {31'd0, oOverflow}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (100) @(posedge Clock);
    #1;
    check("midrst_rx_none", rx_q.size(), 32'd0);
    check("midrst_idle_busy", {31'd0, oBusy}, 32'd0);
    push(8'h5A);
    expect_frame(10'b1010110100, "midrst_clean");
    @(posedge Clock);
    #1;
    check("midrst_clean_busy", {31'd0, oBusy}, 32'd0);

    // 0x00 then 0xFF two cycles apart
    do_reset();
    push(8'h00);
    @(posedge Clock);
    push(8'hFF);
    repeat (90) @(posedge Clock);
    #1;
    exp_rx = '{8'h00, 8'hFF};
    check("pair_rx_count", rx_q.size(), 32'd2);
    for (int i = 0; i < rx_q.size() && i < 2; i++)
      check($sformatf("pair_rx%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_rx[i]});
    check("pair_starts", st_q.size(), 32'd2);
    check_abut("pair");
    check("pair_idle_busy", {31'd0, oBusy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
